// File: rtl/seq_mult.sv
// seq_mult: sequential shift-and-add multiplier, W x W -> 2W.
// One W+1-bit adder is reused for W cycles. Signed operands are converted
// to magnitudes at load time, and the sign is applied to the product once
// in the FIX state.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled in IDLE or DONE only
//   signed_mode  1 = two's-complement operands, sampled with start
//   x, y         multiplicand / multiplier, sampled with start
//   busy         high while an operation is in progress (registered)
//   done         one-cycle completion pulse (registered)
//   p            product register, valid while done = 1
module seq_mult #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t         state_q;
  logic [W:0]     acc_q;
  logic [W-1:0]   mq_q;
  logic [W-1:0]   mcand_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_q;
  logic [2*W-1:0] p_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   x_mag;
  logic [W-1:0]   y_mag;
  logic           neg_d;
  logic [W:0]     sum;
  logic [2*W-1:0] result;
  logic [2*W-1:0] p_d;

  always_comb begin
    // -2^(W-1) negates to itself, which read as unsigned is its magnitude.
    x_mag  = (signed_mode && x[W-1]) ? (~x) + W'(1) : x;
    y_mag  = (signed_mode && y[W-1]) ? (~y) + W'(1) : y;
    neg_d  = signed_mode & (x[W-1] ^ y[W-1]);
    sum    = acc_q + (mq_q[0] ? {1'b0, mcand_q} : '0);
    result = {acc_q[W-1:0], mq_q};
    p_d    = neg_q ? (~result) + (2*W)'(1) : result;
  end

  // busy/done are registered from the current state, so each trails the
  // state it reflects by one edge; this yields the W+2 start-to-done latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_q == S_RUN) || (state_q == S_FIX);
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc_q   <= '0;
            mq_q    <= y_mag;
            mcand_q <= x_mag;
            cnt_q   <= '0;
            neg_q   <= neg_d;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q <= {1'b0, sum[W:1]};
          mq_q  <= {sum[0], mq_q[W-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          p_q     <= p_d;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0, sm8 = 1'b0, busy8, done8;
  logic [7:0]  x8 = '0, y8 = '0;
  logic [15:0] p8;

  logic        start4 = 1'b0, sm4 = 1'b0, busy4, done4;
  logic [3:0]  x4 = '0, y4 = '0;
  logic [7:0]  p4;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  seq_mult #(.W(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .p(p8)
  );

  seq_mult #(.W(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .x(x4), .y(y4), .busy(busy4), .done(done4), .p(p4)
  );

  // Reference: interpret operands as integers, multiply, truncate to 2w bits.
  function automatic logic [63:0] refp(input logic [31:0] a, input logic [31:0] b,
                                       input bit sm, input int w);
    longint sa, sb, prod;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    prod = sa * sb;
    return 64'(prod) & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One W=8 operation; optionally scrambles inputs (and start while it
  // cannot be accepted) during the operation.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                     input string tag, input bit scramble);
    int unsigned lat, bcnt, both;
    @(negedge clk);
    x8 = a; y8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0; bcnt = 0; both = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1 lat++;
      if (busy8) bcnt++;
      if (busy8 && done8) both++;
      if (done8) break;
      if (scramble) begin
        x8 = 8'($urandom); y8 = 8'($urandom); sm8 = 1'($urandom);
        start8 = (lat <= 8) ? 1'($urandom) : 1'b0;
      end
    end
    start8 = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'd10);
    chk({tag, "_p"}, 64'(p8), refp(32'(a), 32'(b), sm, 8));
    chk({tag, "_busy"}, 64'(bcnt), 64'd9);
    chk({tag, "_overlap"}, 64'(both), 64'd0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit sm);
    int unsigned lat;
    @(negedge clk);
    x4 = a; y4 = b; sm4 = sm; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    lat = 0;
    while (lat < 12) begin
      @(posedge clk);
      #1 lat++;
      if (done4) break;
    end
    chk($sformatf("w4_%0d_%0h_%0h_lat", sm, a, b), 64'(lat), 64'd6);
    chk($sformatf("w4_%0d_%0h_%0h_p", sm, a, b), 64'(p4), refp(32'(a), 32'(b), sm, 4));
  endtask

  initial begin
    logic [7:0]  bx [4];
    logic [7:0]  by [4];
    bit          bs [4];
    int unsigned lat, seen;

    // Reset state
    #1;
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_p8", 64'(p8), 64'd0);
    chk("rst_p4", 64'(p4), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Directed cases
    op8(8'd13, 8'd11, 1'b0, "u13x11", 1'b0);
    op8(8'hFF, 8'hFF, 1'b0, "uFFxFF", 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, "sm1xm1", 1'b0);
    op8(8'h80, 8'h80, 1'b1, "s80x80", 1'b0);
    op8(8'hFD, 8'h05, 1'b1, "sm3x5", 1'b0);
    op8(8'h00, 8'h80, 1'b1, "s0x80", 1'b0);
    op8(8'h80, 8'h7F, 1'b1, "s80x7F", 1'b0);
    op8(8'h7F, 8'h00, 1'b0, "u7Fx0", 1'b0);

    // Random operands, inputs scrambled during the operation
    for (int i = 0; i < 8; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i), 1'b1);

    // Back-to-back with start held high
    for (int i = 0; i < 4; i++) begin
      bx[i] = 8'($urandom); by[i] = 8'($urandom); bs[i] = 1'($urandom);
    end
    @(negedge clk);
    x8 = bx[0]; y8 = by[0]; sm8 = bs[0]; start8 = 1'b1;
    @(posedge clk);
    #1 x8 = bx[1]; y8 = by[1]; sm8 = bs[1];
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      while (lat < 20) begin
        @(posedge clk);
        #1 lat++;
        if (done8) break;
      end
      chk($sformatf("b2b%0d_gap", i), 64'(lat), 64'd10);
      chk($sformatf("b2b%0d_p", i), 64'(p8), refp(32'(bx[i]), 32'(by[i]), bs[i], 8));
      if (i + 2 < 4) begin
        x8 = bx[i+2]; y8 = by[i+2]; sm8 = bs[i+2];
      end
      if (i == 2) start8 = 1'b0;
    end
    start8 = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset during the 4th RUN cycle
    op8(8'd200, 8'd3, 1'b0, "pre_rst", 1'b0);
    @(negedge clk);
    x8 = 8'd77; y8 = 8'd91; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy8), 64'd0);
    chk("arst_done", 64'(done8), 64'd0);
    chk("arst_p", 64'(p8), 64'd0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1 if (done8 || busy8) seen++;
    end
    chk("arst_no_done", 64'(seen), 64'd0);
    op8(8'hC3, 8'h5A, 1'b1, "post_rst", 1'b0);

    // W=4 exhaustive, both modes
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op4(4'(a), 4'(b), 1'(s));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
